// File: rtl/sgmii_phy_init_if.sv
// MDIO management bus between the PHY bring-up sequencer and the pad/PHY side.
// Pure signal bundle: no latency, no flow control.
// master drives mdc/mdio_o/mdio_oe, slave returns mdio_i.
interface sgmii_phy_init_if;
    logic mdc;
    logic mdio_o;
    logic mdio_oe;
    logic mdio_i;

    modport master (output mdc, output mdio_o, output mdio_oe, input mdio_i);
    modport slave  (input mdc, input mdio_o, input mdio_oe, output mdio_i);
endinterface

// File: rtl/sgmii_phy_init.sv
// Brings up an SGMII PHY over MDIO, then releases the PCS and watches for receive sync.
// Latency: RESET_WAIT cycles + two write frames + read polls (64 MDC periods each, plus one idle period).
// No backpressure: frames are paced by the internal MDC divider; the FSM only moves on frame done.
module sgmii_phy_init #(
    parameter int         CLK_DIV      = 50,
    parameter logic [4:0] PHY_ADDR     = 5'h00,
    parameter int         RESET_WAIT   = 1250000,
    parameter int         LINK_TIMEOUT = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eth_ready,
    output logic             pcs_reset,
    sgmii_phy_init_if.master mdio,
    output logic             init_done,
    output logic [3:0]       retry_cnt
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = $clog2(CLK_DIV);

    typedef enum logic [2:0] {RST_WAIT, WR_HWCFG, WR_CTRL, POLL, LINK_WAIT, LINK_UP} state_t;
    typedef enum logic [1:0] {F_IDLE, F_ACTIVE, F_GAP} fphase_t;

    state_t        state;
    logic [31:0]   wait_cnt;
    logic [3:0]    poll_cnt;
    logic [9:0]    drop_cnt;

    logic          frm_start;
    logic          frm_read;
    logic [4:0]    frm_reg;
    logic [15:0]   frm_wdata;
    logic          frm_done;
    logic [15:0]   rd_data;

    fphase_t       fphase;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_idx;
    logic [63:0]   tx_sh;
    logic          is_read;
    logic [63:0]   frame;

    // Read frames carry 1s after REGAD; those bits are never driven since oe drops at TA.
    assign frame = frm_read ?
        {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, frm_reg, 18'h3FFFF} :
        {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, frm_reg, 2'b10, frm_wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            fphase       <= F_IDLE;
            div_cnt      <= '0;
            bit_idx      <= '0;
            tx_sh        <= '0;
            is_read      <= 1'b0;
            rd_data      <= '0;
            frm_done     <= 1'b0;
            mdio.mdc     <= 1'b0;
            mdio.mdio_o  <= 1'b1;
            mdio.mdio_oe <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            case (fphase)
                F_IDLE: begin
                    if (frm_start) begin
                        fphase       <= F_ACTIVE;
                        div_cnt      <= '0;
                        bit_idx      <= '0;
                        is_read      <= frm_read;
                        tx_sh        <= {frame[62:0], 1'b1};
                        mdio.mdio_o  <= frame[63];
                        mdio.mdio_oe <= 1'b1;
                    end
                end
                F_ACTIVE: begin
                    div_cnt <= div_cnt + DW'(1);
                    if (div_cnt == DW'(HALF - 1)) begin
                        mdio.mdc <= 1'b1;
                        if (is_read && bit_idx >= 6'd48)
                            rd_data <= {rd_data[14:0], mdio.mdio_i};
                    end
                    // Falling MDC edge is the only point where mdio_o/oe move.
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        mdio.mdc <= 1'b0;
                        if (bit_idx == 6'd63) begin
                            fphase       <= F_GAP;
                            mdio.mdio_oe <= 1'b0;
                            mdio.mdio_o  <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 6'd1;
                            mdio.mdio_o <= tx_sh[63];
                            tx_sh       <= {tx_sh[62:0], 1'b1};
                            if (is_read && bit_idx == 6'd45)
                                mdio.mdio_oe <= 1'b0;
                        end
                    end
                end
                F_GAP: begin
                    div_cnt <= div_cnt + DW'(1);
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        fphase   <= F_IDLE;
                        frm_done <= 1'b1;
                    end
                end
                default: fphase <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_WAIT;
            wait_cnt  <= '0;
            poll_cnt  <= '0;
            drop_cnt  <= '0;
            pcs_reset <= 1'b1;
            init_done <= 1'b0;
            retry_cnt <= '0;
            frm_start <= 1'b0;
            frm_read  <= 1'b0;
            frm_reg   <= '0;
            frm_wdata <= '0;
        end else begin
            frm_start <= 1'b0;
            case (state)
                RST_WAIT: begin
                    pcs_reset <= 1'b1;
                    init_done <= 1'b0;
                    if (wait_cnt == 32'(RESET_WAIT - 1)) begin
                        wait_cnt  <= '0;
                        state     <= WR_HWCFG;
                        frm_start <= 1'b1;
                        frm_read  <= 1'b0;
                        frm_reg   <= 5'h1B;
                        frm_wdata <= 16'h9084;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WR_HWCFG: begin
                    if (frm_done) begin
                        state     <= WR_CTRL;
                        frm_start <= 1'b1;
                        frm_read  <= 1'b0;
                        frm_reg   <= 5'h00;
                        frm_wdata <= 16'h8140;
                    end
                end
                WR_CTRL: begin
                    if (frm_done) begin
                        state     <= POLL;
                        poll_cnt  <= '0;
                        frm_start <= 1'b1;
                        frm_read  <= 1'b1;
                        frm_reg   <= 5'h00;
                    end
                end
                POLL: begin
                    if (frm_done) begin
                        if (!rd_data[15]) begin
                            state     <= LINK_WAIT;
                            pcs_reset <= 1'b0;
                            wait_cnt  <= '0;
                        end else if (poll_cnt == 4'd15) begin
                            state     <= RST_WAIT;
                            wait_cnt  <= '0;
                            pcs_reset <= 1'b1;
                            if (retry_cnt != 4'hF)
                                retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            poll_cnt  <= poll_cnt + 4'd1;
                            frm_start <= 1'b1;
                            frm_read  <= 1'b1;
                            frm_reg   <= 5'h00;
                        end
                    end
                end
                LINK_WAIT: begin
                    pcs_reset <= 1'b0;
                    if (eth_ready) begin
                        state     <= LINK_UP;
                        init_done <= 1'b1;
                        drop_cnt  <= '0;
                    end else if (wait_cnt == 32'(LINK_TIMEOUT - 1)) begin
                        state     <= RST_WAIT;
                        wait_cnt  <= '0;
                        pcs_reset <= 1'b1;
                        if (retry_cnt != 4'hF)
                            retry_cnt <= retry_cnt + 4'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                LINK_UP: begin
                    // Sync glitches shorter than 1024 cycles are filtered out.
                    if (eth_ready) begin
                        drop_cnt <= '0;
                    end else if (drop_cnt == 10'd1023) begin
                        state     <= LINK_WAIT;
                        init_done <= 1'b0;
                        wait_cnt  <= '0;
                        drop_cnt  <= '0;
                    end else begin
                        drop_cnt <= drop_cnt + 10'd1;
                    end
                end
                default: state <= RST_WAIT;
            endcase
        end
    end
endmodule

// File: doc/sgmii_phy_init.md
SGMII_PHY_INIT -- requirements
Module: sgmii_phy_init

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per MDC period (even, >=4); 2.5 MHz MDC at 125 MHz.
REQ-002 SHALL have parameter PHY_ADDR, default 5'h00, meaning MDIO PHY address.
REQ-003 SHALL have parameter RESET_WAIT, default 1250000, meaning clk cycles of wait after reset before first MDIO frame (10 ms).
REQ-004 SHALL have parameter LINK_TIMEOUT, default 12500000, meaning clk cycles allowed for PCS sync before the sequence restarts (100 ms).
REQ-005 SHALL have port clk  input  1  125 MHz clock, the same clock as the PCS.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port eth_ready  input  1  PCS receive-sync indication.
REQ-008 SHALL have port pcs_reset  output  1  holds the PCS in reset until the PHY is configured.
REQ-009 SHALL have port mdc  output  1  MDIO management clock.
REQ-010 SHALL have port mdio_o  output  1  MDIO data out.
REQ-011 SHALL have port mdio_oe  output  1  MDIO output enable; 0 means tristate.
REQ-012 SHALL have port mdio_i  input  1  MDIO data in.
REQ-013 SHALL have port init_done  output  1  PHY configured and PCS in sync.
REQ-014 SHALL have port retry_cnt  output  4  number of sequence restarts, saturating at 15.

Function
REQ-015 SHALL use the state machine RST_WAIT -> WR_HWCFG -> WR_CTRL -> POLL -> LINK_WAIT -> LINK_UP.
REQ-016 RST_WAIT: SHALL count RESET_WAIT cycles, then enter WR_HWCFG.
REQ-017 WR_HWCFG: SHALL send one MDIO write of reg 5'h1B <- 16'h9084 (SGMII, no clock), then enter WR_CTRL.
REQ-018 WR_CTRL: SHALL send one MDIO write of reg 5'h00 <- 16'h8140 (soft reset, 1000 Mb/s, full duplex, autoneg off), then enter POLL.
REQ-019 POLL: SHALL send MDIO reads of reg 5'h00; if read bit15 is 0, enter LINK_WAIT; otherwise send another read; after 16 reads with bit15 still 1, enter RST_WAIT (restart).
REQ-020 LINK_WAIT: SHALL hold pcs_reset=0 and count clk cycles; eth_ready=1 enters LINK_UP; reaching LINK_TIMEOUT enters RST_WAIT (restart).
REQ-021 LINK_UP: SHALL assert init_done=1; eth_ready=0 for 1024 consecutive cycles enters LINK_WAIT with the timeout counter cleared; shorter drops SHALL be ignored.
REQ-022 pcs_reset SHALL be 1 in RST_WAIT, WR_HWCFG, WR_CTRL and POLL, and 0 in LINK_WAIT and LINK_UP.
REQ-023 Every restart SHALL increment retry_cnt, saturating at 15; only reset clears it.
REQ-024 MDC: SHALL toggle every CLK_DIV/2 cycles only while a frame is active, and SHALL be low when idle.
REQ-025 mdio_o SHALL change only on the clk cycle in which mdc falls; mdio_i SHALL be sampled on the cycle mdc rises.
REQ-026 Frame, 64 MDC periods, MSB first: 32 preamble 1s, ST=01, OP=01 for write or 10 for read, PHY_ADDR[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-027 Write frames SHALL drive TA=10 and the data with mdio_oe=1 for all 64 bits.
REQ-028 Read frames SHALL deassert mdio_oe from the first TA bit through the end of the frame and capture 16 data bits MSB first.
REQ-029 After each frame, mdio_oe SHALL be 0 and mdc low for at least one full MDC period before the next frame.
REQ-030 Frame completion SHALL be a single-cycle internal done pulse; the FSM SHALL advance only on it, never mid-frame.

Reset
REQ-031 While reset=1, the block SHALL drive state=RST_WAIT, pcs_reset=1, mdc=0, mdio_o=1, mdio_oe=0, init_done=0, retry_cnt=0, and clear all counters.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with mdio_oe=0 the next cycle; no partial frame resumes.
REQ-033 Any restart (REQ-019, REQ-020) SHALL abort nothing mid-frame, since it occurs only between frames, and SHALL reassert pcs_reset on the transition cycle.

Verification
V1 Set RESET_WAIT=100 and CLK_DIV=4, release reset -> first mdc rise at cycle 100+2 (+/-1); the write frame bits decode as 1x32, 01, 01, 00000, 11011, 10, 16'h9084.
V2 Use a PHY model returning reg0=16'h8140 for 2 reads, then 16'h0140 -> exactly 3 read frames, mdio_oe=0 during TA/data, then pcs_reset falls.
V3 Use a PHY model that always returns bit15=1 -> 16 reads, then restart, retry_cnt=1, pcs_reset stays 1 throughout.
V4 Hold eth_ready=0 in LINK_WAIT with LINK_TIMEOUT=500 -> restart at cycle 500, pcs_reset=1, retry_cnt increments; force 20 restarts -> retry_cnt=15.
V5 In LINK_UP, drop eth_ready for 1023 cycles -> init_done stays 1; drop for 1024 cycles -> init_done=0 and pcs_reset stays 0.
V6 Assert reset at bit 40 of the WR_CTRL frame -> next cycle mdio_oe=0 and mdc=0; after release the sequence restarts from RST_WAIT with a full WR_HWCFG frame.
